// File: rtl/seq_det_if.sv
// Host/stream-side bundle for the serial pattern-detection controller.
// The master drives stream and config; the slave (controller) returns status.
interface seq_det_if #(
    parameter int unsigned PW = 8,
    parameter int unsigned CW = 8
);
    logic          din;
    logic          din_valid;
    logic          cfg_we;
    logic [PW-1:0] cfg_pattern;
    logic [3:0]    cfg_len;
    logic          cfg_overlap;
    logic [CW-1:0] cfg_thresh;
    logic          start;
    logic          stop;
    logic          busy;
    logic          match;
    logic [CW-1:0] match_cnt;
    logic          done;

    modport master (
        output din, din_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
               start, stop,
        input  busy, match, match_cnt, done
    );

    modport slave (
        input  din, din_valid, cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
               start, stop,
        output busy, match, match_cnt, done
    );
endinterface

// File: rtl/seq_det_ctrl.sv
// Run-time configurable serial pattern detector with arm/run/stop sequencing,
// match counting and threshold-based completion.
module seq_det_ctrl #(
    parameter int unsigned PW = 8,
    parameter int unsigned CW = 8
) (
    input  logic     clk,
    input  logic     rst,
    seq_det_if.slave bus
);
    localparam int unsigned FW = $clog2(PW + 1);
    localparam int unsigned LW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pat_q, pat_d;
    logic [LW-1:0] len_q, len_d;
    logic          ovl_q, ovl_d;
    logic [CW-1:0] thr_q, thr_d;
    // Only the newest PW-1 bits need keeping; the incoming bit completes the window.
    logic [PW-2:0] hist_q, hist_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          match_q, match_d;
    logic          done_q, done_d;

    logic [LW-1:0] len_eff_c;
    logic [PW-1:0] hist_n_c;
    logic [FW-1:0] fill_n_c;
    logic [PW-1:0] mask_c;
    logic [CW-1:0] cnt_inc_c;
    logic          hit_c;

    // Window, fill, compare mask and saturating count for the current bit.
    always_comb begin
        len_eff_c = bus.cfg_len;
        if (bus.cfg_len == '0)
            len_eff_c = LW'(1);
        else if (32'(bus.cfg_len) > PW)
            len_eff_c = LW'(PW);

        hist_n_c  = {hist_q, bus.din};
        fill_n_c  = (fill_q == FW'(PW)) ? fill_q : fill_q + FW'(1);
        for (int unsigned i = 0; i < PW; i++)
            mask_c[i] = (i < 32'(len_q));
        hit_c     = (32'(fill_n_c) >= 32'(len_q)) && ((hist_n_c & mask_c) == (pat_q & mask_c));
        cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        thr_d   = thr_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;

        if (bus.cfg_we && (state_q == IDLE || state_q == DONE)) begin
            pat_d = bus.cfg_pattern;
            len_d = len_eff_c;
            ovl_d = bus.cfg_overlap;
            thr_d = bus.cfg_thresh;
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    hist_d  = '0;
                    fill_d  = '0;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (bus.din_valid) begin
                    hist_d = hist_n_c[PW-2:0];
                    fill_d = fill_n_c;
                    if (hit_c) begin
                        match_d = 1'b1;
                        cnt_d   = cnt_inc_c;
                        if (!ovl_q)
                            fill_d = '0;
                        if (thr_q != '0 && cnt_inc_c == thr_q)
                            state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= LW'(1);
            ovl_q   <= 1'b0;
            thr_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            thr_q   <= thr_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            match_q <= match_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed, self-checking bench for seq_det_ctrl; expected match/count per
// accepted bit is queued at drive time and compared once the DUT responds.
module tb_seq_det_ctrl;
    localparam int unsigned PW = 8;
    localparam int unsigned CW = 8;

    typedef struct packed {
        logic          m;
        logic [CW-1:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];

    seq_det_if #(.PW(PW), .CW(CW)) bus ();

    seq_det_ctrl #(.PW(PW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic b, input logic d, input logic [CW-1:0] c);
        chk({tag, "_busy"}, 32'(bus.busy), 32'(b));
        chk({tag, "_done"}, 32'(bus.done), 32'(d));
        chk({tag, "_cnt"},  32'(bus.match_cnt), 32'(c));
    endtask

    task automatic cfg(input logic [PW-1:0] pat, input logic [3:0] len, input logic ov,
                       input logic [CW-1:0] th);
        bus.cfg_we      = 1'b1;
        bus.cfg_pattern = pat;
        bus.cfg_len     = len;
        bus.cfg_overlap = ov;
        bus.cfg_thresh  = th;
        step();
        bus.cfg_we      = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
    endtask

    // Drive one bit (optionally valid), queue the expectation, then compare.
    task automatic send(input string tag, input logic b, input logic v,
                        input logic em, input logic [CW-1:0] ec);
        exp_t e;
        exp_t got;
        e.m = em;
        e.c = ec;
        sb.push_back(e);
        bus.din       = b;
        bus.din_valid = v;
        step();
        bus.din_valid = 1'b0;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, "_match"}, 32'(bus.match), 32'(got.m));
            chk({tag, "_cnt"},   32'(bus.match_cnt), 32'(got.c));
        end
    endtask

    initial begin
        bus.din = 1'b0; bus.din_valid = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0; bus.cfg_thresh = '0;
        bus.start = 1'b0; bus.stop = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk("rst_match", 32'(bus.match), 32'(0));
        chk_status("rst", 1'b0, 1'b0, 8'd0);
        rst = 1'b0;

        // Non-overlapping 1011 on stream 1011011
        cfg(8'b0000_1011, 4'd4, 1'b0, 8'd0);
        do_start();
        chk_status("no_start", 1'b1, 1'b0, 8'd0);
        send("no_b1", 1, 1, 0, 0); send("no_b2", 0, 1, 0, 0);
        send("no_b3", 1, 1, 0, 0); send("no_b4", 1, 1, 1, 1);
        send("no_b5", 0, 1, 0, 1); send("no_b6", 1, 1, 0, 1);
        send("no_b7", 1, 1, 0, 1);
        do_stop();
        chk_status("no_stop", 1'b0, 1'b0, 8'd1);

        // Overlapping: second match reuses the shared '1'
        cfg(8'b0000_1011, 4'd4, 1'b1, 8'd0);
        do_start();
        chk_status("ov_start", 1'b1, 1'b0, 8'd0);
        send("ov_b1", 1, 1, 0, 0); send("ov_b2", 0, 1, 0, 0);
        send("ov_b3", 1, 1, 0, 0); send("ov_b4", 1, 1, 1, 1);
        send("ov_b5", 0, 1, 0, 1); send("ov_b6", 1, 1, 0, 1);
        send("ov_b7", 1, 1, 1, 2);
        do_stop();

        // Threshold of 2 completes on the seventh bit
        cfg(8'b0000_1011, 4'd4, 1'b1, 8'd2);
        do_start();
        send("th_b1", 1, 1, 0, 0); send("th_b2", 0, 1, 0, 0);
        send("th_b3", 1, 1, 0, 0); send("th_b4", 1, 1, 1, 1);
        chk_status("th_mid", 1'b1, 1'b0, 8'd1);
        send("th_b5", 0, 1, 0, 1); send("th_b6", 1, 1, 0, 1);
        send("th_b7", 1, 1, 1, 2);
        chk_status("th_done", 1'b0, 1'b1, 8'd2);
        send("th_x1", 1, 1, 0, 2); send("th_x2", 0, 1, 0, 2);
        send("th_x3", 1, 1, 0, 2); send("th_x4", 1, 1, 0, 2);
        chk_status("th_hold", 1'b0, 1'b1, 8'd2);
        do_start();
        chk_status("th_rearm", 1'b1, 1'b0, 8'd0);
        do_stop();
        chk_status("th_stop", 1'b0, 1'b0, 8'd0);

        // len=0 clamps to 1; stalls between valid bits
        cfg(8'b0000_0001, 4'd0, 1'b0, 8'd0);
        do_start();
        send("l0_b1", 1, 1, 1, 1); send("l0_s1", 1, 0, 0, 1);
        send("l0_b2", 0, 1, 0, 1); send("l0_s2", 1, 0, 0, 1);
        send("l0_b3", 1, 1, 1, 2);
        do_stop();

        // len=12 clamps to 8
        cfg(8'b1011_0011, 4'd12, 1'b0, 8'd0);
        do_start();
        send("l12_b1", 1, 1, 0, 0); send("l12_b2", 0, 1, 0, 0);
        send("l12_b3", 1, 1, 0, 0); send("l12_b4", 1, 1, 0, 0);
        send("l12_b5", 0, 1, 0, 0); send("l12_b6", 0, 1, 0, 0);
        send("l12_b7", 1, 1, 0, 0); send("l12_b8", 1, 1, 1, 1);
        do_stop();

        // Config writes during RUN are ignored
        cfg(8'b0000_1011, 4'd4, 1'b0, 8'd0);
        do_start();
        cfg(8'b0000_0110, 4'd4, 1'b0, 8'd1);
        send("lk_b1", 1, 1, 0, 0); send("lk_b2", 0, 1, 0, 0);
        send("lk_b3", 1, 1, 0, 0); send("lk_b4", 1, 1, 1, 1);
        chk_status("lk_run", 1'b1, 1'b0, 8'd1);

        // stop and start together: stop wins, count retained
        bus.stop = 1'b1; bus.start = 1'b1;
        step();
        bus.stop = 1'b0; bus.start = 1'b0;
        chk_status("ss", 1'b0, 1'b0, 8'd1);
        step();
        chk_status("ss_hold", 1'b0, 1'b0, 8'd1);

        // Reset mid-run restores outputs and config
        do_start();
        send("rs_b1", 1, 1, 0, 0); send("rs_b2", 0, 1, 0, 0);
        send("rs_b3", 1, 1, 0, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rs_match", 32'(bus.match), 32'(0));
        chk_status("rs", 1'b0, 1'b0, 8'd0);
        do_start();
        send("rs_b4", 1, 1, 0, 0);
        // Reset config is pattern=0, len=1: a single '0' now matches
        send("rs_z", 0, 1, 1, 1);
        do_stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
